// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// The loader attaches through the master modport; stream source and memory use slave.
interface imem_loader_if #(
   parameter int WIDTH    = 32,
   parameter int ADDR_LEN = 8
);
   logic                s_valid;
   logic [7:0]          s_data;
   logic                s_ready;
   logic                mem_wr_en;
   logic [ADDR_LEN-1:0] mem_addr;
   logic [WIDTH-1:0]    mem_wr_data;

   modport master (
      input  s_valid, s_data,
      output s_ready, mem_wr_en, mem_addr, mem_wr_data
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, mem_wr_en, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream into instruction memory,
// XOR-checksum verified, holding the core in reset until a good image is present.
module imem_loader #(
   parameter int WIDTH    = 32,
   parameter int ADDR_LEN = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   imem_loader_if.master  bus,
   output logic           core_rst_n,
   input  logic           halt,
   output logic           done,
   output logic           error
);
   localparam int LANES  = WIDTH / 8;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [16:0]       CAPACITY  = 17'(1) << ADDR_LEN;

   localparam logic [2:0] S_LEN_LO = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CSUM   = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   logic [2:0]          state_r;
   logic [2:0]          state_nxt_s;
   logic [15:0]         len_r;
   logic [LANE_W-1:0]   byte_cnt_r;
   logic [16:0]         word_idx_r;
   logic [7:0]          csum_r;
   logic [WIDTH-1:0]    word_r;
   logic                wr_en_r;
   logic [ADDR_LEN-1:0] addr_r;
   logic [WIDTH-1:0]    wdata_r;
   logic                ready_r;
   logic                run_r;
   logic                err_r;

   logic                accept_s;
   logic [16:0]         len_s;
   logic [WIDTH-1:0]    word_asm_s;
   logic                last_lane_s;
   logic                last_word_s;

   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // Accept decode, word assembly and next-state selection.
   always_comb begin
      accept_s    = bus.s_valid && ready_r;
      len_s       = {1'b0, bus.s_data, len_r[7:0]};
      word_asm_s  = word_r;
      word_asm_s[{byte_cnt_r, 3'b000} +: 8] = bus.s_data;
      last_lane_s = (byte_cnt_r == LAST_LANE);
      last_word_s = ((word_idx_r + 17'd1) == {1'b0, len_r});
      state_nxt_s = state_r;
      case (state_r)
         S_LEN_LO: begin
            if (accept_s) state_nxt_s = S_LEN_HI;
            else          state_nxt_s = state_r;
         end
         S_LEN_HI: begin
            if (!accept_s)             state_nxt_s = state_r;
            else if (len_s == 17'd0)   state_nxt_s = S_CSUM;
            else if (len_s > CAPACITY) state_nxt_s = S_ERR;
            else                       state_nxt_s = S_DATA;
         end
         S_DATA: begin
            if (accept_s && last_lane_s && last_word_s) state_nxt_s = S_CSUM;
            else                                        state_nxt_s = state_r;
         end
         S_CSUM: begin
            if (!accept_s)                   state_nxt_s = state_r;
            else if (bus.s_data == csum_r)   state_nxt_s = S_RUN;
            else                             state_nxt_s = S_ERR;
         end
         S_RUN: begin
            if (halt) state_nxt_s = S_LEN_LO;
            else      state_nxt_s = state_r;
         end
         S_ERR:   state_nxt_s = S_ERR;
         default: state_nxt_s = S_ERR;
      endcase
   end

   // State register with status outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_LEN_LO;
         ready_r <= 1'b1;
         run_r   <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == S_LEN_LO) || (state_nxt_s == S_LEN_HI) ||
                    (state_nxt_s == S_DATA)   || (state_nxt_s == S_CSUM);
         run_r   <= (state_nxt_s == S_RUN);
         err_r   <= (state_nxt_s == S_ERR);
      end
   end

   // Length capture, word assembly, checksum and memory write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r      <= 16'd0;
         byte_cnt_r <= '0;
         word_idx_r <= 17'd0;
         csum_r     <= 8'd0;
         word_r     <= '0;
         wr_en_r    <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
      end else begin
         wr_en_r <= 1'b0;
         case (state_r)
            S_LEN_LO: if (accept_s) len_r[7:0]  <= bus.s_data;
            S_LEN_HI: if (accept_s) len_r[15:8] <= bus.s_data;
            S_DATA: begin
               if (accept_s) begin
                  word_r <= word_asm_s;
                  csum_r <= csum_next(csum_r, bus.s_data);
                  if (last_lane_s) begin
                     wr_en_r    <= 1'b1;
                     addr_r     <= word_idx_r[ADDR_LEN-1:0];
                     wdata_r    <= word_asm_s;
                     word_idx_r <= word_idx_r + 17'd1;
                     byte_cnt_r <= '0;
                  end else begin
                     byte_cnt_r <= byte_cnt_r + LANE_W'(1);
                  end
               end
            end
            // Halt rearms the loader for a fresh image; memory is left intact.
            S_RUN: begin
               if (halt) begin
                  word_idx_r <= 17'd0;
                  byte_cnt_r <= '0;
                  csum_r     <= 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.s_ready     = ready_r;
   assign bus.mem_wr_en   = wr_en_r;
   assign bus.mem_addr    = addr_r;
   assign bus.mem_wr_data = wdata_r;
   assign core_rst_n      = run_r;
   assign done            = run_r;
   assign error           = err_r;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one task per scenario, inline checks against
// hand-computed write logs and status values.
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic halt = 1'b0;
   logic core_rst_n, done, error;

   imem_loader_if #(.WIDTH(32), .ADDR_LEN(8)) bus();

   imem_loader #(.WIDTH(32), .ADDR_LEN(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master),
      .core_rst_n(core_rst_n), .halt(halt), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int gap_mode = 0;
   logic [7:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   // Write log: every cycle with mem_wr_en high adds one entry.
   always @(negedge clk) begin
      if (bus.mem_wr_en === 1'b1) begin
         wr_addr_q.push_back(bus.mem_addr);
         wr_data_q.push_back(bus.mem_wr_data);
      end
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation exceeded 1 ms, expected completion");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      halt        = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   // Presents one byte and returns right after the edge that accepts it.
   task automatic send_byte(input logic [7:0] b);
      int budget;
      @(negedge clk);
      if (gap_mode != 0) begin
         bus.s_valid = 1'b0;
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      budget = 0;
      while (bus.s_ready !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) begin
         vectors++; miscompares++;
         $display("FAIL send_stall: s_ready=%b for 50 cycles, expected 1", bus.s_ready);
      end
      @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({bus.s_ready, bus.mem_wr_en, core_rst_n, done, error} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 10000",
                  {bus.s_ready, bus.mem_wr_en, core_rst_n, done, error});
      end
      vectors++;
      if (bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_bus: addr=%h data=%h expected 00/00000000", bus.mem_addr, bus.mem_wr_data);
      end
   endtask

   // N=2 image; payload XOR 13^EF^BE^AD^DE = 31.
   task automatic test_n2(input int gaps);
      do_reset();
      gap_mode = gaps;
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0000_0013);
      send_word(32'hDEAD_BEEF);
      #1;
      vectors++;
      if (done !== 1'b0 || core_rst_n !== 1'b0) begin
         miscompares++;
         $display("FAIL n2_early_run g%0d: done=%b core_rst_n=%b expected 0/0", gaps, done, core_rst_n);
      end
      send_byte(8'h31);
      #1;
      vectors++;
      if ({core_rst_n, done, error, bus.s_ready} !== 4'b1100) begin
         miscompares++;
         $display("FAIL n2_run g%0d: core_rst_n,done,error,s_ready=%b expected 1100", gaps,
                  {core_rst_n, done, error, bus.s_ready});
      end
      idle();
      gap_mode = 0;
      vectors++;
      if (wr_addr_q.size() !== 2) begin
         miscompares++;
         $display("FAIL n2_wr_count g%0d: got %0d expected 2", gaps, wr_addr_q.size());
      end else begin
         vectors++;
         if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL n2_wr0 g%0d: got %h/%h expected 00/00000013", gaps, wr_addr_q[0], wr_data_q[0]);
         end
         vectors++;
         if (wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL n2_wr1 g%0d: got %h/%h expected 01/deadbeef", gaps, wr_addr_q[1], wr_data_q[1]);
         end
      end
      vectors++;
      if (bus.mem_addr !== 8'd1 || bus.mem_wr_data !== 32'hDEAD_BEEF || bus.mem_wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL n2_hold g%0d: addr=%h data=%h wr_en=%b expected 01/deadbeef/0", gaps,
                  bus.mem_addr, bus.mem_wr_data, bus.mem_wr_en);
      end
   endtask

   task automatic test_n0();
      do_reset();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      #1;
      vectors++;
      if ({done, core_rst_n, error} !== 3'b110) begin
         miscompares++;
         $display("FAIL n0_good: done,core_rst_n,error=%b expected 110", {done, core_rst_n, error});
      end
      idle();
      vectors++;
      if (wr_addr_q.size() !== 0) begin
         miscompares++;
         $display("FAIL n0_writes: got %0d expected 0", wr_addr_q.size());
      end
      do_reset();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      #1;
      vectors++;
      if ({done, core_rst_n, error} !== 3'b001) begin
         miscompares++;
         $display("FAIL n0_bad: done,core_rst_n,error=%b expected 001", {done, core_rst_n, error});
      end
      idle();
   endtask

   // Payload XOR of 11223344 is 44, so CSUM 00 must fail.
   task automatic test_bad_csum();
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h1122_3344);
      send_byte(8'h00);
      #1;
      vectors++;
      if ({error, bus.s_ready, core_rst_n} !== 3'b100) begin
         miscompares++;
         $display("FAIL badcs_err: error,s_ready,core_rst_n=%b expected 100", {error, bus.s_ready, core_rst_n});
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(8'hA0 + i);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({error, bus.s_ready, done} !== 3'b100) begin
         miscompares++;
         $display("FAIL badcs_sticky: error,s_ready,done=%b expected 100", {error, bus.s_ready, done});
      end
      vectors++;
      if (wr_addr_q.size() !== 1 || wr_data_q[0] !== 32'h1122_3344 || wr_addr_q[0] !== 8'd0) begin
         miscompares++;
         $display("FAIL badcs_writes: count=%0d first=%h expected 1 write of 11223344 at 00",
                  wr_addr_q.size(), wr_data_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0000_0013);
      send_byte(8'hEF); send_byte(8'hBE);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.s_ready, bus.mem_wr_en, core_rst_n, done, error} !== 5'b10000 ||
          bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 32'h0) begin
         miscompares++;
         $display("FAIL midrst_async: flags=%b addr=%h data=%h expected 10000/00/00000000",
                  {bus.s_ready, bus.mem_wr_en, core_rst_n, done, error}, bus.mem_addr, bus.mem_wr_data);
      end
      vectors++;
      if (wr_addr_q.size() !== 1) begin
         miscompares++;
         $display("FAIL midrst_partial: writes=%0d expected 1", wr_addr_q.size());
      end
      bus.s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr_addr_q.delete();
      wr_data_q.delete();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0000_0013);
      send_word(32'hDEAD_BEEF);
      send_byte(8'h31);
      idle();
      vectors++;
      if (wr_addr_q.size() !== 2 || wr_addr_q[0] !== 8'd0 || wr_data_q[1] !== 32'hDEAD_BEEF || done !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_reload: count=%0d addr0=%h data1=%h done=%b expected 2/00/deadbeef/1",
                  wr_addr_q.size(), wr_addr_q[0], wr_data_q[1], done);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      send_byte(8'h01); send_byte(8'h01);
      #1;
      vectors++;
      if ({error, bus.s_ready, done} !== 3'b100) begin
         miscompares++;
         $display("FAIL ovf_257: error,s_ready,done=%b expected 100", {error, bus.s_ready, done});
      end
      idle();
   endtask

   task automatic test_full_capacity();
      logic [7:0]  cs;
      logic [31:0] w;
      logic [7:0]  b;
      do_reset();
      cs = 8'h00;
      send_byte(8'h00); send_byte(8'h01);
      for (int i = 0; i < 256; i++) begin
         b = 8'(i);
         w = {b ^ 8'h5A, b, ~b, 8'h3C};
         cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send_word(w);
      end
      send_byte(cs);
      idle();
      vectors++;
      if (wr_addr_q.size() !== 256 || done !== 1'b1 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL full_count: writes=%0d done=%b error=%b expected 256/1/0", wr_addr_q.size(), done, error);
      end else begin
         vectors++;
         if (wr_addr_q[255] !== 8'hFF || wr_data_q[255] !== 32'hA5FF003C || wr_addr_q[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL full_last: addr=%h data=%h first=%h expected ff/a5ff003c/00",
                     wr_addr_q[255], wr_data_q[255], wr_addr_q[0]);
         end
      end
   endtask

   // CSUM of CAFEF00D is 0D^F0^FE^CA = C9.
   task automatic test_halt_reload();
      do_reset();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0000_0013);
      send_word(32'hDEAD_BEEF);
      send_byte(8'h31);
      idle();
      halt = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({core_rst_n, bus.s_ready, done, error} !== 4'b0100) begin
         miscompares++;
         $display("FAIL halt_rearm: core_rst_n,s_ready,done,error=%b expected 0100",
                  {core_rst_n, bus.s_ready, done, error});
      end
      @(negedge clk);
      halt = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'hCAFE_F00D);
      send_byte(8'hC9);
      idle();
      vectors++;
      if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'hCAFE_F00D ||
          done !== 1'b1 || core_rst_n !== 1'b1) begin
         miscompares++;
         $display("FAIL halt_reload: count=%0d addr=%h data=%h done=%b expected 1/00/cafef00d/1",
                  wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], done);
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      test_reset();
      test_n2(0);
      test_n2(1);
      test_n0();
      test_bad_csum();
      test_reset_mid();
      test_overflow();
      test_full_capacity();
      test_halt_reload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
